// File: rtl/io_pad_receiver_if.sv
// rtl/io_pad_receiver_if.sv - load handshake interface between pad receiver and counter core
//
// Purpose: carries the parallel load word and its valid/ready handshake.
// Signals:
//   load_valid  producer -> consumer  load_data holds a complete frame
//   load_data   producer -> consumer  received word, first bit received = MSB
//   load_ready  consumer -> producer  consumer accepts load_data this cycle
// Modports: master = receiver side (drives valid/data), slave = consumer side.
`timescale 1ns/1ps
interface io_pad_receiver_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/io_pad_receiver.sv
// rtl/io_pad_receiver.sv - synchronise, debounce and deframe pad inputs into a load word
//
// Purpose: terminates four raw pad inputs. Each pin is synchronised and
// debounced; the frame/strobe/data pins are decoded into a WIDTH-bit load
// word presented on a valid/ready handshake, and pin 3 is exported as a
// level count enable.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   pin_in     raw pads: [0] serial data, [1] strobe, [2] frame, [3] count enable
//   load_if    master side of the load handshake (load_valid/load_data/load_ready)
//   cnt_en     debounced pin_in[3]
//   frame_err  one-cycle pulse when a frame is discarded
`timescale 1ns/1ps
module io_pad_receiver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          pin_in,
  io_pad_receiver_if.master   load_if,
  output logic                cnt_en,
  output logic                frame_err
);

  localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int BCW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       deb_q;
  logic [3:0]       deb_prev_q;
  logic [CW-1:0]    deb_cnt_q [4];
  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic             load_valid_q;
  logic [WIDTH-1:0] load_data_q;
  logic             frame_err_q;

  logic [3:0] sync_w;
  logic       rise_frame;
  logic       fall_frame;
  logic       rise_strobe;

  assign sync_w      = sync_q[SYNC_STAGES-1];
  assign rise_frame  =  deb_q[2] & ~deb_prev_q[2];
  assign fall_frame  = ~deb_q[2] &  deb_prev_q[2];
  assign rise_strobe =  deb_q[1] & ~deb_prev_q[1];

  // Synchroniser chain, debounce and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        if (sync_w[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          // Mismatch has persisted DEBOUNCE cycles: accept the new level.
          deb_q[i]     <= sync_w[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Frame decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Only an edge starts a frame, so a frame still high on return
          // from HOLD is ignored; a coincident strobe rise is not shifted.
          if (rise_frame) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall_frame) begin
            if (bit_cnt_q == BCW'(WIDTH)) begin
              load_data_q  <= shift_q;
              load_valid_q <= 1'b1;
              state_q      <= HOLD;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end
          end else if (rise_strobe) begin
            shift_q <= {shift_q[WIDTH-2:0], deb_q[0]};
            // Saturate one past WIDTH so overlong frames stay distinguishable.
            if (bit_cnt_q != BCW'(WIDTH + 1)) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (rise_frame) frame_err_q <= 1'b1;
          if (load_if.load_ready) begin
            load_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_if.load_valid = load_valid_q;
  assign load_if.load_data  = load_data_q;
  assign cnt_en             = deb_q[3];
  assign frame_err          = frame_err_q;

endmodule

// File: tb/tb_io_pad_receiver.sv
// tb/tb_io_pad_receiver.sv - self-checking bench for io_pad_receiver
`timescale 1ns/1ps
module tb_io_pad_receiver;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pin;
  logic       cnt_en;
  logic       frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  io_pad_receiver_if #(.WIDTH(WIDTH)) lif ();

  io_pad_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_in    (pin),
    .load_if   (lif),
    .cnt_en    (cnt_en),
    .frame_err (frame_err)
  );

  always #50 clk = ~clk;

  // Event monitor: frame_err pulses, over-wide pulses, load_valid rises.
  int   err_cnt  = 0;
  int   err_wide = 0;
  int   lv_rise  = 0;
  logic prev_err = 1'b0;
  logic prev_lv  = 1'b0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      err_cnt++;
      if (prev_err === 1'b1) err_wide++;
    end
    if (lif.load_valid === 1'b1 && prev_lv !== 1'b1) lv_rise++;
    prev_err = frame_err;
    prev_lv  = lif.load_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a frame of exactly WIDTH strobes yields the bits packed
  // first-received-as-MSB; anything else is discarded with an error.
  function automatic logic [31:0] exp_word(input logic [7:0] bits, input int n);
    logic [31:0] w = 0;
    for (int i = 0; i < n; i++) w = w * 2 + 32'(bits[i]);
    return w;
  endfunction

  // Each level is held 8 cycles so every debounced pin sees it cleanly.
  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      pin[0] = bits[i]; tick(8);
      pin[1] = 1'b1;    tick(8);
      pin[1] = 1'b0;    tick(8);
    end
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n);
    pin[2] = 1'b1; tick(8);
    send_bits(bits, n);
    pin[2] = 1'b0; tick(12);
  endtask

  task automatic accept(input string tag);
    lif.load_ready = 1'b1;
    tick(1);
    chk(tag, lif.load_valid, 0);
    lif.load_ready = 1'b0;
    tick(2);
  endtask

  int   e0;
  int   l0;
  logic seen;
  logic [7:0] rbits;
  int   rn;
  logic [31:0] held;

  initial begin
    rst = 1'b1;
    pin = 4'hF;
    lif.load_ready = 1'b0;

    // Reset with all pads high.
    tick(3);
    chk("rst_valid", lif.load_valid, 0);
    chk("rst_data", lif.load_data, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b0;
    tick(5);
    chk("cnt_en_lat5", cnt_en, 0);
    tick(1);
    chk("cnt_en_lat6", cnt_en, 1);
    pin = 4'h0;
    tick(14);
    chk("cnt_en_low", cnt_en, 0);

    // Glitch rejection then acceptance on the count-enable pin.
    pin[3] = 1'b1; tick(3); pin[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(1); seen |= cnt_en; end
    chk("glitch_reject", seen, 0);
    pin[3] = 1'b1; tick(4); pin[3] = 1'b0;
    tick(1);
    chk("cnt_en_pin5", cnt_en, 0);
    tick(1);
    chk("cnt_en_pin6", cnt_en, 1);
    tick(14);

    // Good frame 1,0,1,1.
    e0 = err_cnt; l0 = lv_rise;
    send_frame(8'b0000_1101, 4);
    chk("good_valid", lif.load_valid, 1);
    chk("good_data", lif.load_data, 32'hB);
    chk("good_model", lif.load_data, exp_word(8'b0000_1101, 4));
    chk("good_noerr", err_cnt - e0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (lif.load_valid !== 1'b1 || lif.load_data !== 4'hB) seen = 1'b1;
    end
    chk("hold_stable", seen, 0);
    accept("good_accept");

    // Short and overlong frames.
    e0 = err_cnt; l0 = lv_rise;
    send_frame(8'b0000_0101, 3);
    chk("short_err", err_cnt - e0, 1);
    chk("short_noload", lv_rise - l0, 0);
    e0 = err_cnt;
    send_frame(8'b0010_1101, 6);
    chk("long_err", err_cnt - e0, 1);
    chk("long_noload", lv_rise - l0, 0);
    chk("long_valid", lif.load_valid, 0);

    // Overrun: second frame 0,1,0,0 arrives while holding 4'hB.
    send_frame(8'b0000_1101, 4);
    e0 = err_cnt; l0 = lv_rise;
    send_frame(8'b0000_0010, 4);
    chk("ovr_err", err_cnt - e0, 1);
    chk("ovr_data", lif.load_data, 32'hB);
    chk("ovr_valid", lif.load_valid, 1);
    accept("ovr_accept");
    tick(12);
    chk("ovr_noload", lv_rise - l0, 0);
    chk("ovr_valid_after", lif.load_valid, 0);

    // Reset mid-frame, then a full frame 0,1,1,0.
    e0 = err_cnt;
    pin[2] = 1'b1; tick(8);
    send_bits(8'b0000_0011, 2);
    rst = 1'b1; pin = 4'h0;
    tick(3);
    chk("midrst_valid", lif.load_valid, 0);
    chk("midrst_data", lif.load_data, 0);
    rst = 1'b0;
    tick(12);
    send_frame(8'b0000_0110, 4);
    chk("after_rst_valid", lif.load_valid, 1);
    chk("after_rst_data", lif.load_data, 32'h6);
    chk("after_rst_noerr", err_cnt - e0, 0);
    accept("after_rst_accept");

    // Randomised frames against the reference.
    for (int r = 0; r < 8; r++) begin
      rn = $urandom_range(3, 6);
      if ($urandom_range(0, 1) == 1) rn = WIDTH;
      rbits = 8'($urandom);
      e0 = err_cnt; l0 = lv_rise;
      send_frame(rbits, rn);
      if (rn == WIDTH) begin
        held = exp_word(rbits, rn);
        chk($sformatf("rnd%0d_valid", r), lif.load_valid, 1);
        chk($sformatf("rnd%0d_data", r), lif.load_data, held);
        chk($sformatf("rnd%0d_noerr", r), err_cnt - e0, 0);
        accept($sformatf("rnd%0d_accept", r));
      end else begin
        chk($sformatf("rnd%0d_err", r), err_cnt - e0, 1);
        chk($sformatf("rnd%0d_noload", r), lv_rise - l0, 0);
      end
    end

    chk("err_single_cycle", err_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_pad_receiver.md
Name: io_pad_receiver

Overview:
- Input-side counterpart of the pad wrapper; terminates the pad pins configured as inputs (io_in[7:4] in the top-level).
- Synchronises and debounces 4 raw pad inputs, then decodes a strobed serial frame into a parallel load word for the counter.
- Also exports a level count-enable.
- Sits between the pad ring and the counter core; all outputs are registered.

Parameters:
- WIDTH, 4: bits per serial frame and width of load_data.
- SYNC_STAGES, 2: synchroniser flops per pin, minimum 2.
- DEBOUNCE, 4: consecutive stable synchronised cycles required to accept a pin change, minimum 1.

Ports:
- clk  input  1  system clock (10 MHz).
- rst  input  1  synchronous, active-high reset.
- pin_in  input  4  raw pad inputs: [0] serial data, [1] strobe, [2] frame, [3] count enable.
- load_ready  input  1  consumer accepts load_data this cycle.
- load_valid  output  1  load_data holds a complete frame.
- load_data  output  WIDTH  received word, first bit received = MSB.
- cnt_en  output  1  debounced pin_in[3].
- frame_err  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset:
  - One clock is decided; reset is synchronous and active-high, sampled on the clk rising edge.
  - All synchroniser flops, debounced values, edge registers, debounce counters, shift register and bit count go to 0.
  - State goes to IDLE.
  - Outputs: load_valid=0, load_data=0, cnt_en=0, frame_err=0.
  - Reset asserted mid-frame or in HOLD drops the frame silently; frame_err stays 0.
- Synchroniser:
  - SYNC_STAGES-flop chain per pin.
  - The last stage is sync[i].
- Debounce (per pin):
  - The counter clears whenever sync[i]==deb[i].
  - While sync[i]!=deb[i], the counter increments.
  - When the counter reaches DEBOUNCE-1 with a mismatch still present: deb[i]<=sync[i] and the counter clears.
  - Pin-to-deb latency: exactly SYNC_STAGES+DEBOUNCE cycles.
  - Glitches shorter than DEBOUNCE cycles at sync produce no change.
- Edge detect:
  - rise[i] = deb[i] & ~deb_d[i]; fall[i] = ~deb[i] & deb_d[i].
  - deb_d is deb delayed one cycle.
- cnt_en = deb[3], level, no further delay.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: on rise[2], clear shift register and bit count, go to SHIFT. A strobe rise in the same cycle is not shifted.
  - SHIFT, on rise[1] without fall[2]:
    - shift_reg <= {shift_reg[WIDTH-2:0], deb[0]}.
    - bit_count increments, saturating at WIDTH+1.
  - SHIFT, on fall[2] (takes priority over a simultaneous rise[1], which is dropped):
    - If bit_count==WIDTH: load_data<=shift_reg, load_valid<=1 on the next edge, go to HOLD.
    - Otherwise (short or overlong frame): frame_err=1 for one cycle, go to IDLE.
  - HOLD:
    - load_valid=1 and load_data stays stable until sampled with load_ready=1.
    - On that edge load_valid<=0 and the state goes to IDLE.
    - rise[2] in HOLD: frame_err pulses one cycle; that frame is ignored entirely.
    - Returning to IDLE while frame is still high does not start a frame; a new rise[2] is required.
  - load_ready while not in HOLD has no effect.
- Ordering: frame_err and the load_valid rise occur 1 cycle after the triggering edge-detect cycle.

Test Plan:
- Reset: hold rst=1 for 3 cycles with pin_in=4'hF, then release.
  - Required during reset: all outputs 0.
  - Required after release: cnt_en rises exactly SYNC_STAGES+DEBOUNCE = 6 cycles after rst deasserts.
- Glitch rejection: pulse pin_in[3] high for 3 cycles (DEBOUNCE=4) -> cnt_en stays 0.
  - Then hold it high for 4 cycles -> cnt_en=1 at pin+6.
- Good frame: frame high, 4 strobes with data 1,0,1,1 (each level held ≥8 cycles), frame low.
  - Required: load_valid=1 with load_data=4'hB.
  - With load_ready held 0 for 10 cycles, both remain stable.
  - load_ready=1 -> load_valid=0 on the next cycle.
- Short/long frame: 3 strobes -> frame_err single-cycle pulse, load_valid stays 0. Repeat with 6 strobes -> same result.
- Overrun: a second frame with data 0,1,0,0 starts while in HOLD with load_data=4'hB.
  - Required: frame_err pulses once; load_data remains 4'hB.
  - After load_ready, no load for the dropped frame.
- Reset mid-frame: assert rst after 2 strobes, release, send a full frame 4'h6.
  - Required: load_data=4'h6 and no frame_err.
